// File: rtl/ace_inst_queue.sv
// Compacting circular instruction queue between fetch and the decode ways.
// Sparse fetch lanes are packed in order at the tail; the oldest DEC_W entries are presented at the head.
module ace_inst_queue #(
  parameter int unsigned FETCH_W = 8,
  parameter int unsigned DEC_W   = 4,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned INST_W  = 32,
  parameter int unsigned PC_W    = 64
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush_i,
  input  logic [FETCH_W*INST_W-1:0]     fetch_inst_i,
  input  logic [FETCH_W-1:0]            fetch_vld_i,
  input  logic [PC_W-1:0]               fetch_pc_i,
  output logic                          fetch_rdy_o,
  output logic [DEC_W*INST_W-1:0]       dec_inst_o,
  output logic [DEC_W*PC_W-1:0]         dec_pc_o,
  output logic [DEC_W-1:0]              dec_vld_o,
  input  logic [$clog2(DEC_W+1)-1:0]    deq_cnt_i,
  output logic [$clog2(DEPTH+1)-1:0]    cnt_o,
  output logic                          full_o,
  output logic                          empty_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned POP_W = $clog2(FETCH_W + 1);

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [PC_W-1:0]   mem_pc   [DEPTH];

  logic [PTR_W-1:0]  head_q;
  logic [PTR_W-1:0]  tail_q;
  logic [CNT_W-1:0]  cnt_q;

  logic [PTR_W-1:0]  lane_off [FETCH_W];
  logic [PTR_W-1:0]  wr_idx   [FETCH_W];
  logic [POP_W-1:0]  pop_cnt;
  logic [CNT_W-1:0]  enq_cnt;
  logic [CNT_W-1:0]  deq_lim;
  logic [CNT_W-1:0]  eff_deq;
  logic              enq;

  // Prefix count of valid lanes gives each lane its compacted slot past the tail.
  always_comb begin
    pop_cnt = '0;
    for (int k = 0; k < FETCH_W; k++) begin
      lane_off[k] = PTR_W'(pop_cnt);
      wr_idx[k]   = tail_q + PTR_W'(pop_cnt);
      pop_cnt     = pop_cnt + POP_W'(fetch_vld_i[k]);
    end
  end

  // Ready reflects registered occupancy only; a same-cycle dequeue gives no credit.
  assign fetch_rdy_o = (CNT_W'(DEPTH) - cnt_q) >= CNT_W'(FETCH_W);
  assign enq         = fetch_rdy_o & (|fetch_vld_i) & ~flush_i;
  assign enq_cnt     = enq ? CNT_W'(pop_cnt) : '0;
  assign deq_lim     = (cnt_q < CNT_W'(DEC_W)) ? cnt_q : CNT_W'(DEC_W);
  assign eff_deq     = (CNT_W'(deq_cnt_i) < deq_lim) ? CNT_W'(deq_cnt_i) : deq_lim;

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_q + PTR_W'(eff_deq);
      tail_q <= tail_q + PTR_W'(enq_cnt);
      cnt_q  <= cnt_q + enq_cnt - eff_deq;
    end
  end

  // Storage carries no reset; only pointer and count state define validity.
  always_ff @(posedge clock) begin
    if (enq && !reset) begin
      for (int k = 0; k < FETCH_W; k++) begin
        if (fetch_vld_i[k]) begin
          mem_inst[wr_idx[k]] <= fetch_inst_i[k*INST_W +: INST_W];
          mem_pc[wr_idx[k]]   <= fetch_pc_i + PC_W'(4 * k);
        end
      end
    end
  end

  for (genvar i = 0; i < DEC_W; i++) begin : g_way
    logic [PTR_W-1:0] rd_idx;
    assign rd_idx                         = head_q + PTR_W'(i);
    assign dec_inst_o[i*INST_W +: INST_W] = mem_inst[rd_idx];
    assign dec_pc_o[i*PC_W +: PC_W]       = mem_pc[rd_idx];
    assign dec_vld_o[i]                   = CNT_W'(i) < cnt_q;
  end

  assign cnt_o   = cnt_q;
  assign full_o  = cnt_q == CNT_W'(DEPTH);
  assign empty_o = cnt_q == '0;

  // Decode asking for more than is presented is clamped, but worth flagging.
  always_ff @(posedge clock) begin
    if (!reset && !flush_i) begin
      assert (CNT_W'(deq_cnt_i) <= deq_lim)
        else $warning("ace_inst_queue: deq_cnt_i=%0d over-requests %0d presented, clamped",
                      deq_cnt_i, deq_lim);
    end
  end

endmodule

// File: tb/tb_ace_inst_queue.sv
// Scoreboard bench for ace_inst_queue: the driver pushes expected post-edge state from a
// reference FIFO, and a monitor pops and compares it in the cycle the DUT presents it.
module tb_ace_inst_queue;

  localparam int unsigned FETCH_W = 8;
  localparam int unsigned DEC_W   = 4;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned INST_W  = 32;
  localparam int unsigned PC_W    = 64;

  logic                       clock = 1'b0;
  logic                       reset;
  logic                       flush_i;
  logic [FETCH_W*INST_W-1:0]  fetch_inst_i;
  logic [FETCH_W-1:0]         fetch_vld_i;
  logic [PC_W-1:0]            fetch_pc_i;
  logic                       fetch_rdy_o;
  logic [DEC_W*INST_W-1:0]    dec_inst_o;
  logic [DEC_W*PC_W-1:0]      dec_pc_o;
  logic [DEC_W-1:0]           dec_vld_o;
  logic [2:0]                 deq_cnt_i;
  logic [4:0]                 cnt_o;
  logic                       full_o;
  logic                       empty_o;

  ace_inst_queue #(
    .FETCH_W(FETCH_W), .DEC_W(DEC_W), .DEPTH(DEPTH), .INST_W(INST_W), .PC_W(PC_W)
  ) dut (
    .clock(clock), .reset(reset), .flush_i(flush_i),
    .fetch_inst_i(fetch_inst_i), .fetch_vld_i(fetch_vld_i), .fetch_pc_i(fetch_pc_i),
    .fetch_rdy_o(fetch_rdy_o), .dec_inst_o(dec_inst_o), .dec_pc_o(dec_pc_o),
    .dec_vld_o(dec_vld_o), .deq_cnt_i(deq_cnt_i), .cnt_o(cnt_o),
    .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    int           cyc;
    int           tag;
    logic [4:0]   cnt;
    logic         rdy;
    logic         full;
    logic         empty;
    logic [3:0]   vld;
    logic [255:0] pcs;
    logic [127:0] insts;
  } exp_t;

  exp_t        exp_q[$];
  logic [95:0] refq[$];   // {pc, inst}, front = oldest
  int          cyc   = 0;
  int          tests = 0;
  int          fails = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic cmp(input string nm, input int tag, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s tag=%0d got=%h want=%h", nm, tag, act, want);
    end
  endtask

  task automatic check(input exp_t e);
    cmp("cnt_o",       e.tag, 64'(cnt_o),       64'(e.cnt));
    cmp("fetch_rdy_o", e.tag, 64'(fetch_rdy_o), 64'(e.rdy));
    cmp("full_o",      e.tag, 64'(full_o),      64'(e.full));
    cmp("empty_o",     e.tag, 64'(empty_o),     64'(e.empty));
    cmp("dec_vld_o",   e.tag, 64'(dec_vld_o),   64'(e.vld));
    for (int i = 0; i < DEC_W; i++) begin
      if (e.vld[i]) begin
        cmp($sformatf("pc_way%0d", i),   e.tag, dec_pc_o[i*64 +: 64], e.pcs[i*64 +: 64]);
        cmp($sformatf("inst_way%0d", i), e.tag, 64'(dec_inst_o[i*32 +: 32]), 64'(e.insts[i*32 +: 32]));
      end
    end
  endtask

  // Monitor: compare every expectation that targets the edge just taken.
  always @(posedge clock) begin
    #2;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      check(exp_q.pop_front());
    end
  end

  // Drive one cycle of stimulus, update the reference FIFO, queue the expected result.
  task automatic step(input logic [7:0] vld, input logic [63:0] pc, input int deq,
                      input bit fl, input bit rs, input int tag);
    exp_t        e;
    logic [31:0] inst;
    int          eff;
    bit          rdy;
    reset       = rs;
    flush_i     = fl;
    fetch_vld_i = vld;
    fetch_pc_i  = pc;
    deq_cnt_i   = 3'(deq);
    for (int k = 0; k < FETCH_W; k++) begin
      inst = {pc[15:0], 8'(tag), 8'(k)};
      fetch_inst_i[k*32 +: 32] = inst;
    end
    if (rs || fl) begin
      refq.delete();
    end else begin
      rdy = (DEPTH - refq.size()) >= FETCH_W;
      eff = deq;
      if (eff > refq.size()) eff = refq.size();
      if (eff > DEC_W) eff = DEC_W;
      repeat (eff) void'(refq.pop_front());
      if (rdy) begin
        for (int k = 0; k < FETCH_W; k++) begin
          if (vld[k]) refq.push_back({pc + 64'(4 * k), fetch_inst_i[k*32 +: 32]});
        end
      end
    end
    e.cyc   = cyc + 1;
    e.tag   = tag;
    e.cnt   = 5'(refq.size());
    e.rdy   = (DEPTH - refq.size()) >= FETCH_W;
    e.full  = refq.size() == DEPTH;
    e.empty = refq.size() == 0;
    e.vld   = '0;
    e.pcs   = '0;
    e.insts = '0;
    for (int i = 0; i < DEC_W; i++) begin
      if (i < refq.size()) begin
        e.vld[i]            = 1'b1;
        e.pcs[i*64 +: 64]   = refq[i][95:32];
        e.insts[i*32 +: 32] = refq[i][31:0];
      end
    end
    exp_q.push_back(e);
    @(posedge clock);
    #1;
  endtask

  logic [7:0] vld_tab [8] = '{8'hFF, 8'h81, 8'h7E, 8'h00, 8'h13, 8'hF0, 8'h55, 8'h0F};
  int         deq_tab [9] = '{4, 3, 4, 2, 4, 1, 4, 0, 3};

  initial begin
    int d;
    reset        = 1'b1;
    flush_i      = 1'b0;
    fetch_vld_i  = '0;
    fetch_pc_i   = '0;
    fetch_inst_i = '0;
    deq_cnt_i    = '0;
    @(posedge clock);
    #1;
    // Reset state
    step(8'h00, 64'h0, 0, 0, 1, 1);
    step(8'h00, 64'h0, 0, 0, 1, 2);
    // Full bundle: 8 entries, PCs 0x1000..0x100C presented
    step(8'hFF, 64'h1000, 0, 0, 0, 10);
    step(8'h00, 64'h0,    0, 1, 0, 11);
    // Sparse bundle: lanes 0,2,5,7 -> PCs 0x2000,0x2008,0x2014,0x201C
    step(8'b1010_0101, 64'h2000, 0, 0, 0, 20);
    step(8'h00, 64'h0, 0, 1, 0, 21);
    // Fill to 16, hold a bundle while full, drain 4+4, held bundle accepted
    step(8'hFF, 64'h3000, 0, 0, 0, 30);
    step(8'hFF, 64'h3020, 0, 0, 0, 31);
    for (int h = 0; h < 3; h++) step(8'hFF, 64'h3040, 0, 0, 0, 32 + h);
    step(8'hFF, 64'h3040, 4, 0, 0, 35);
    step(8'hFF, 64'h3040, 4, 0, 0, 36);
    step(8'hFF, 64'h3040, 0, 0, 0, 37);
    step(8'h00, 64'h0, 0, 1, 0, 38);
    // Simultaneous enqueue/dequeue: 6 + 8 - 4 = 10
    step(8'h3F, 64'h4000, 0, 0, 0, 40);
    step(8'hFF, 64'h5000, 4, 0, 0, 41);
    // Streaming across the pointer wrap
    for (int s = 0; s < 25; s++) begin
      d = deq_tab[s % 9];
      if (d > refq.size()) d = refq.size();
      step(vld_tab[s % 8], 64'h10000 + 64'(s * 64), d, 0, 0, 100 + s);
    end
    step(8'h00, 64'h0, 0, 1, 0, 49);
    // Over-request: cnt 2, deq 4 -> clamped to empty
    step(8'h03, 64'h6000, 0, 0, 0, 50);
    step(8'h00, 64'h0,    4, 0, 0, 51);
    // Flush at cnt 12 with a bundle and deq 3: everything dropped
    step(8'hFF, 64'h7000, 0, 0, 0, 60);
    step(8'h0F, 64'h7020, 0, 0, 0, 61);
    step(8'hFF, 64'h8000, 3, 1, 0, 62);
    step(8'h0F, 64'h8100, 0, 0, 0, 63);
    // Reset mid-stream behaves like flush
    step(8'hFF, 64'h9000, 1, 0, 0, 70);
    step(8'hFF, 64'h9100, 3, 0, 1, 71);
    step(8'h81, 64'h9200, 0, 0, 0, 72);
    reset       = 1'b0;
    flush_i     = 1'b0;
    fetch_vld_i = '0;
    deq_cnt_i   = '0;
    repeat (4) @(posedge clock);
    #3;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain pending=%0d want=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
